// File: rtl/udp_img_pkg.sv
// Shared constants, FSM encoding and header byte selection for the UDP image packetizer.
// The UDP_TX_TEST_PATTERN_EN build option is handled in udp_pixel_serializer and the top.
package udp_img_pkg;

  localparam logic [31:0] IMG_HEADER        = 32'hAA0055FF;
  localparam int unsigned IMG_HEADER_LEN    = 32;
  localparam int unsigned IMG_DATA_LEN      = 636;
  localparam int unsigned TOTAL_PACKET_LEN  = 668;
  localparam int unsigned PIXELS_PER_PACKET = 212;
  localparam int unsigned LAST_FRAMSEQ      = 1449;

  localparam int unsigned IMG_WIDTH   = 640;
  localparam int unsigned IMG_HEIGHT  = 480;
  localparam int unsigned PIXEL_COUNT = 307200;
  localparam int unsigned GAP_CYCLES  = 256;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StGap,
    StArb,
    StHeader,
    StData
  } state_e;

  // Header is eight 32-bit fields sent LSB first; idx[4:2] picks the field, idx[1:0] the byte.
  function automatic logic [7:0] hdr_byte(input logic [4:0]  idx,
                                          input logic [31:0] total,
                                          input logic [31:0] offset,
                                          input logic [31:0] picseq,
                                          input logic [10:0] framseq);
    logic [31:0] field;
    unique case (idx[4:2])
      3'd0:    field = IMG_HEADER;
      3'd1:    field = 32'(IMG_WIDTH);
      3'd2:    field = 32'(IMG_HEIGHT);
      3'd3:    field = total;
      3'd4:    field = offset;
      3'd5:    field = picseq;
      3'd6:    field = {21'd0, framseq};
      default: field = 32'(IMG_DATA_LEN);
    endcase
    return field[{idx[1:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/udp_pixel_serializer.sv
// Pixel prefetch, next-pixel register and G,R,B byte shifter with zero padding past frame end.
// With UDP_TX_TEST_PATTERN_EN defined, pixels come from an 8-bar colour generator instead.
module udp_pixel_serializer
  import udp_img_pkg::*;
#(
  parameter int unsigned PixelCount = PIXEL_COUNT
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        clear_i,
  input  logic        hdr_i,
  input  logic        dat_i,
  input  logic [9:0]  byte_cnt_i,
  output logic        read_en_o,
  input  logic [31:0] read_data_i,
  output logic [7:0]  byte_o
);

  logic [18:0] pix_cnt_q;
  logic [1:0]  phase_q;
  logic [23:0] nxt_q;
  logic [23:0] sh_q;
  logic        strobe, load, fetch;

  // Fetch pixel k while pixel k-1 starts; the first pixel of a packet is fetched at header byte 28.
  assign strobe = (hdr_i && byte_cnt_i == 10'd28) ||
                  (dat_i && phase_q == 2'd0 && byte_cnt_i < 10'(TOTAL_PACKET_LEN - 3));
  assign load   = (hdr_i && byte_cnt_i == 10'(IMG_HEADER_LEN - 1)) ||
                  (dat_i && phase_q == 2'd2);
  assign fetch  = strobe && (pix_cnt_q < 19'(PixelCount));
  assign byte_o = sh_q[23:16];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pix_cnt_q <= '0;
      phase_q   <= '0;
      sh_q      <= '0;
    end else begin
      if (clear_i)    pix_cnt_q <= '0;
      else if (fetch) pix_cnt_q <= pix_cnt_q + 19'd1;
      if (!dat_i)                phase_q <= 2'd0;
      else if (phase_q == 2'd2)  phase_q <= 2'd0;
      else                       phase_q <= phase_q + 2'd1;
      if (load)       sh_q <= nxt_q;
      else if (dat_i) sh_q <= {sh_q[15:0], 8'h00};
    end
  end

`ifdef UDP_TX_TEST_PATTERN_EN
  logic [6:0] col_q;
  logic [2:0] bar_q;
  logic       unused_data;

  assign read_en_o   = 1'b0;
  assign unused_data = ^read_data_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      col_q <= '0;
      bar_q <= '0;
      nxt_q <= '0;
    end else begin
      if (clear_i) begin
        col_q <= '0;
        bar_q <= '0;
      end else if (fetch) begin
        col_q <= (col_q == 7'd79) ? 7'd0 : col_q + 7'd1;
        if (col_q == 7'd79) bar_q <= bar_q + 3'd1;
      end
      if (strobe) nxt_q <= fetch ? {{8{bar_q[1]}}, {8{bar_q[2]}}, {8{bar_q[0]}}} : 24'd0;
    end
  end
`else
  logic strobe_q, fetch_q;
  logic unused_lsb;

  assign read_en_o  = fetch;
  assign unused_lsb = ^read_data_i[7:0];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      strobe_q <= 1'b0;
      fetch_q  <= 1'b0;
      nxt_q    <= '0;
    end else begin
      strobe_q <= strobe;
      fetch_q  <= fetch;
      // Word arrives the clock after read_en; store it already in G,R,B wire order.
      if (strobe_q) begin
        nxt_q <= fetch_q ? {read_data_i[23:16], read_data_i[31:24], read_data_i[15:8]} : 24'd0;
      end
    end
  end
`endif

endmodule

// File: rtl/sdram_to_udp_packet.sv
// Frame-to-UDP packetizer: one frame becomes a run of 668-byte payloads (32-byte header + pixels).
// Define UDP_TX_TEST_PATTERN_EN to replace frame-buffer reads with an internal colour-bar source.
module sdram_to_udp_packet
  import udp_img_pkg::*;
#(
  parameter int unsigned PixelCount = PIXEL_COUNT,
  parameter int unsigned GapCycles  = GAP_CYCLES
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        frame_start_i,
  output logic        busy_o,
  output logic        read_req_o,
  input  logic        read_req_ack_i,
  output logic        read_en_o,
  input  logic [31:0] read_data_i,
  output logic        tx_req_o,
  input  logic        tx_grant_i,
  output logic        udp_tx_data_valid_o,
  output logic [7:0]  udp_tx_data_o,
  output logic [15:0] udp_tx_data_length_o
);

  localparam int unsigned LastFramseq =
      (PixelCount + PIXELS_PER_PACKET - 1) / PIXELS_PER_PACKET - 1;
  localparam logic [31:0] TotalBytes = 32'(PixelCount * 3);

  state_e      state_q, state_d;
  logic [15:0] gap_q, gap_d;
  logic [9:0]  byte_q, byte_d;
  logic [10:0] framseq_q, framseq_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] picseq_q, picseq_d;
  logic        clear;
  logic [7:0]  ser_byte;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      gap_q     <= '0;
      byte_q    <= '0;
      framseq_q <= '0;
      offset_q  <= '0;
      picseq_q  <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      byte_q    <= byte_d;
      framseq_q <= framseq_d;
      offset_q  <= offset_d;
      picseq_q  <= picseq_d;
    end
  end

`ifdef UDP_TX_TEST_PATTERN_EN
  logic unused_ack;
  assign unused_ack = read_req_ack_i;
`endif

  always_comb begin
    state_d             = state_q;
    gap_d               = gap_q;
    byte_d              = byte_q;
    framseq_d           = framseq_q;
    offset_d            = offset_q;
    picseq_d            = picseq_q;
    clear               = 1'b0;
    read_req_o          = 1'b0;
    tx_req_o            = 1'b0;
    udp_tx_data_valid_o = 1'b0;
    udp_tx_data_o       = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (frame_start_i) begin
          state_d   = StRdReq;
          clear     = 1'b1;
          framseq_d = '0;
          offset_d  = '0;
          gap_d     = '0;
        end
      end
      StRdReq: begin
`ifdef UDP_TX_TEST_PATTERN_EN
        state_d = StGap;
`else
        read_req_o = 1'b1;
        if (read_req_ack_i) state_d = StGap;
`endif
      end
      StGap: begin
        if (gap_q == 16'(GapCycles - 1)) begin
          gap_d   = '0;
          state_d = StArb;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      StArb: begin
        tx_req_o = 1'b1;
        if (tx_grant_i) begin
          state_d = StHeader;
          byte_d  = '0;
        end
      end
      StHeader: begin
        udp_tx_data_valid_o = 1'b1;
        udp_tx_data_o = hdr_byte(byte_q[4:0], TotalBytes, offset_q, picseq_q, framseq_q);
        byte_d = byte_q + 10'd1;
        if (byte_q == 10'(IMG_HEADER_LEN - 1)) state_d = StData;
      end
      StData: begin
        udp_tx_data_valid_o = 1'b1;
        udp_tx_data_o       = ser_byte;
        byte_d              = byte_q + 10'd1;
        if (byte_q == 10'(TOTAL_PACKET_LEN - 1)) begin
          byte_d = '0;
          if (framseq_q < 11'(LastFramseq)) begin
            framseq_d = framseq_q + 11'd1;
            offset_d  = offset_q + 32'(IMG_DATA_LEN);
            state_d   = StGap;
          end else begin
            picseq_d = picseq_q + 32'd1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    udp_tx_data_length_o = (tx_req_o || udp_tx_data_valid_o) ? 16'(TOTAL_PACKET_LEN) : 16'd0;
  end

  assign busy_o = (state_q != StIdle);

  udp_pixel_serializer #(
    .PixelCount (PixelCount)
  ) u_serializer (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .clear_i     (clear),
    .hdr_i       (state_q == StHeader),
    .dat_i       (state_q == StData),
    .byte_cnt_i  (byte_q),
    .read_en_o   (read_en_o),
    .read_data_i (read_data_i),
    .byte_o      (ser_byte)
  );

endmodule

// File: tb/tb_sdram_to_udp_packet.sv
// Directed bench for sdram_to_udp_packet on a reduced 648-pixel frame (4 packets) and short gap.
module tb_sdram_to_udp_packet;

  localparam int unsigned PixCnt = 648;
  localparam int unsigned Gap    = 16;
  localparam int unsigned PktLen = 668;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        frame_start = 1'b0;
  logic        read_req_ack = 1'b0;
  logic        tx_grant = 1'b0;
  logic [31:0] read_data = '0;
  logic        busy, read_req, read_en, tx_req, valid;
  logic [7:0]  data;
  logic [15:0] length;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];
  int unsigned rd_total = 0;
  int unsigned fb_idx = 0;
  bit          trunc = 1'b0;
  bit          have_prev = 1'b0;
  int unsigned run = 0;
  int unsigned low_run = 0;

  always #5 clk_i = ~clk_i;

  sdram_to_udp_packet #(
    .PixelCount (PixCnt),
    .GapCycles  (Gap)
  ) dut (
    .clk_i                (clk_i),
    .reset_ni             (reset_ni),
    .frame_start_i        (frame_start),
    .busy_o               (busy),
    .read_req_o           (read_req),
    .read_req_ack_i       (read_req_ack),
    .read_en_o            (read_en),
    .read_data_i          (read_data),
    .tx_req_o             (tx_req),
    .tx_grant_i           (tx_grant),
    .udp_tx_data_valid_o  (valid),
    .udp_tx_data_o        (data),
    .udp_tx_data_length_o (length)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame buffer: rewinds on read_req_ack, returns word = index<<8 the clock after read_en.
  always @(posedge clk_i) begin
    if (read_req_ack) begin
      fb_idx <= 0;
    end else if (read_en) begin
      read_data <= {fb_idx[23:0], 8'h00};
      fb_idx    <= fb_idx + 1;
    end
    if (read_en) rd_total <= rd_total + 1;
  end

  // Output monitor: pops the scoreboard per valid byte and checks burst and gap lengths.
  always @(negedge clk_i) begin
    if (valid) begin
      if (!have_prev || run != 0) begin
      end else begin
        chk("gap_low_min", 32'(low_run >= Gap + 1), 32'd1);
      end
      run++;
      low_run = 0;
      if (exp_q.size() == 0) begin
        chk("byte_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("byte", 32'(data), 32'(exp_q.pop_front()));
        chk("len_valid", 32'(length), 32'(PktLen));
      end
    end else begin
      low_run++;
      if (run != 0) begin
        if (!trunc) chk("valid_run", run, PktLen);
        run       = 0;
        trunc     = 1'b0;
        have_prev = 1'b1;
        low_run   = 1;
      end
    end
  end

  task automatic push_packet(input int unsigned f, input int unsigned pic);
    logic [31:0] hdr[8];
    int unsigned p;
    hdr = '{32'hAA0055FF, 32'd640, 32'd480, 32'(PixCnt * 3), 32'(f * 636), 32'(pic),
            32'(f), 32'd636};
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(hdr[i] >> (8 * b)));
    for (int j = 0; j < 212; j++) begin
      p = f * 212 + 32'(j);
      if (p < PixCnt) begin
        exp_q.push_back(8'(p >> 8));
        exp_q.push_back(8'(p >> 16));
        exp_q.push_back(8'(p));
      end else begin
        repeat (3) exp_q.push_back(8'h00);
      end
    end
  endtask

  task automatic start_frame();
    @(posedge clk_i); #1 frame_start = 1'b1;
    @(posedge clk_i); #1 frame_start = 1'b0;
    @(negedge clk_i);
    chk("busy_start", 32'(busy), 32'd1);
    chk("read_req_up", 32'(read_req), 32'd1);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1 read_req_ack = 1'b1;
    @(posedge clk_i); #1 read_req_ack = 1'b0;
    @(negedge clk_i);
    chk("read_req_down", 32'(read_req), 32'd0);
  endtask

  task automatic do_packet(input int unsigned f, input int unsigned pic, input int unsigned dly,
                           input bit fs_last, input int unsigned cut);
    bit          seen;
    int unsigned r0, exp_rd;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk_i);
      seen = tx_req;
    end
    chk("tx_req_seen", 32'(seen), 32'd1);
    if (!seen) return;
    push_packet(f, pic);
    r0 = rd_total;
    chk("len_arb", 32'(length), 32'(PktLen));
    if (dly > 0) begin
      repeat (dly) @(negedge clk_i);
      chk("tx_req_hold", 32'(tx_req), 32'd1);
      chk("no_early_bytes", 32'(exp_q.size()), 32'(PktLen));
    end
    tx_grant = 1'b1;
    @(posedge clk_i); #1 tx_grant = 1'b0;
    @(negedge clk_i);
    chk("tx_req_drop", 32'(tx_req), 32'd0);
    if (cut > 0) begin
      repeat (cut) @(posedge clk_i);
      #1 trunc = 1'b1;
      reset_ni = 1'b0;
      @(negedge clk_i);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_tx_req", 32'(tx_req), 32'd0);
      chk("rst_read_en", 32'(read_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      @(posedge clk_i); #1 reset_ni = 1'b1;
      return;
    end
    repeat (PktLen - 1) @(posedge clk_i);
    #1 frame_start = fs_last;
    @(posedge clk_i); #1 frame_start = 1'b0;
    @(negedge clk_i);
    chk("valid_end", 32'(valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_rd = (PixCnt - f * 212 >= 212) ? 212 : PixCnt - f * 212;
    chk("pkt_reads", rd_total - r0, exp_rd);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned fr0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_read_req0", 32'(read_req), 32'd0);
    chk("rst_read_en0", 32'(read_en), 32'd0);
    chk("rst_tx_req0", 32'(tx_req), 32'd0);
    chk("rst_valid0", 32'(valid), 32'd0);
    chk("rst_data0", 32'(data), 32'd0);
    chk("rst_len0", 32'(length), 32'd0);
    @(posedge clk_i); #1 reset_ni = 1'b1;

    // Frame 0: delayed grant, stray frame_start and grant, frame_start on the final byte.
    start_frame();
    fr0 = rd_total;
    do_packet(0, 0, 0, 1'b0, 0);
    @(posedge clk_i); #1 frame_start = 1'b1;
    @(posedge clk_i); #1 frame_start = 1'b0;
    @(negedge clk_i);
    chk("fs_midframe_busy", 32'(busy), 32'd1);
    chk("fs_midframe_rdreq", 32'(read_req), 32'd0);
    do_packet(1, 0, 50, 1'b0, 0);
    @(posedge clk_i); #1 tx_grant = 1'b1;
    @(posedge clk_i); #1 tx_grant = 1'b0;
    do_packet(2, 0, 0, 1'b0, 0);
    do_packet(3, 0, 0, 1'b1, 0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("fs_last_ignored", 32'(read_req), 32'd0);
    chk("frame_reads", rd_total - fr0, PixCnt);

    // Frame 1: picseq advances; reset lands on data byte 300 of packet 2.
    start_frame();
    do_packet(0, 1, 0, 1'b0, 0);
    do_packet(1, 1, 0, 1'b0, 0);
    do_packet(2, 1, 0, 1'b0, 32 + 300);

    // After reset the counters restart from zero.
    start_frame();
    do_packet(0, 0, 0, 1'b0, 0);

    repeat (4) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
